// File: rtl/irq_controller.sv
// Machine-level external interrupt controller: synchronises raw sources, latches level/edge
// pending state, and arbitrates lowest-index-first through a claim/complete register interface.
module irq_controller #(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_SOURCES-1:0] irq_src_i,
    input  logic [31:0]            addr_i,
    input  logic                   read_enable_i,
    output logic [31:0]            read_data_o,
    input  logic                   write_enable_i,
    input  logic [31:0]            write_data_i,
    output logic                   interrupt_o
);

    localparam int N = NUM_SOURCES;

    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;
    logic [N-1:0] sync3_q, sync3_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] enable_q, enable_d;
    logic [N-1:0] edge_q, edge_d;
    logic [N-1:0] in_service_q, in_service_d;
    logic [31:0]  read_data_q, read_data_d;
    logic         interrupt_q, interrupt_d;

    logic [N-1:0] eligible;
    logic [N-1:0] rise;
    logic [N-1:0] claim_hit;
    logic [4:0]   best_id;
    logic         wr_pending, wr_enable, wr_edge, wr_claim, rd_claim;
    logic         unused_addr;

    assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    assign wr_pending = write_enable_i && (addr_i[3:2] == 2'd0);
    assign wr_enable  = write_enable_i && (addr_i[3:2] == 2'd1);
    assign wr_edge    = write_enable_i && (addr_i[3:2] == 2'd2);
    assign wr_claim   = write_enable_i && (addr_i[3:2] == 2'd3);
    assign rd_claim   = read_enable_i  && (addr_i[3:2] == 2'd3);

    assign eligible = pending_q & enable_q & ~in_service_q;
    assign rise     = sync2_q & ~sync3_q;

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        best_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) best_id = 5'(i + 1);
        end
    end

    always_comb begin
        claim_hit = '0;
        for (int i = 0; i < N; i++) begin
            claim_hit[i] = rd_claim && (best_id == 5'(i + 1));
        end
    end

    always_comb begin
        sync1_d      = irq_src_i;
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        pending_d    = pending_q;
        in_service_d = in_service_q;
        enable_d     = wr_enable ? write_data_i[N-1:0] : enable_q;
        edge_d       = wr_edge   ? write_data_i[N-1:0] : edge_q;
        interrupt_d  = |eligible;
        for (int i = 0; i < N; i++) begin
            // A fresh edge outranks a same-cycle claim or W1C so no event is dropped.
            if (edge_q[i]) begin
                pending_d[i] = rise[i] |
                               (pending_q[i] & ~(claim_hit[i] | (wr_pending & write_data_i[i])));
            end else begin
                pending_d[i] = sync2_q[i];
            end
            if (wr_claim && (write_data_i == 32'(i + 1))) in_service_d[i] = 1'b0;
            if (claim_hit[i]) in_service_d[i] = 1'b1;
        end
    end

    always_comb begin
        read_data_d = '0;
        if (read_enable_i) begin
            case (addr_i[3:2])
                2'd0:    read_data_d = 32'(pending_q);
                2'd1:    read_data_d = 32'(enable_q);
                2'd2:    read_data_d = 32'(edge_q);
                default: read_data_d = 32'(best_id);
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            edge_q       <= '0;
            in_service_q <= '0;
            read_data_q  <= '0;
            interrupt_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            edge_q       <= edge_d;
            in_service_q <= in_service_d;
            read_data_q  <= read_data_d;
            interrupt_q  <= interrupt_d;
        end
    end

    assign read_data_o = read_data_q;
    assign interrupt_o = interrupt_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register reads are checked by a scoreboard monitor,
// interrupt timing and reset behaviour by direct checks at fixed points.
module tb_irq_controller;

  localparam int NS = 8;
  localparam logic [31:0] A_PEND = 32'h0, A_EN = 32'h4, A_EDGE = 32'h8, A_CLAIM = 32'hC;

  logic          clk;
  logic          rst;
  logic [NS-1:0] src;
  logic [31:0]   addr;
  logic          re;
  logic [31:0]   rdata;
  logic          we;
  logic [31:0]   wdata;
  logic          irq;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          total;
  int          bad;

  irq_controller #(.NUM_SOURCES(NS)) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .irq_src_i     (src),
    .addr_i        (addr),
    .read_enable_i (re),
    .read_data_o   (rdata),
    .write_enable_i(we),
    .write_data_i  (wdata),
    .interrupt_o   (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick(1);
    we = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    re = 1'b1; addr = a;
    tick(1);
    re = 1'b0;
  endtask

  task automatic claim_and_complete(input logic [31:0] id, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    re = 1'b1; we = 1'b1; addr = A_CLAIM; wdata = id;
    tick(1);
    re = 1'b0; we = 1'b0; wdata = '0;
  endtask

  // scoreboard monitor: read data is valid on the negedge after the strobe is sampled
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge clk);
      if (re === 1'b1 && rst === 1'b0) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got 0x%0h expected no read", rdata);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, rdata, e);
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; src = '0; addr = '0; re = 1'b0; we = 1'b0; wdata = '0;
    #1 rst = 1'b1;
    tick(2);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    tick(1);

    // level latency, claim, complete
    bus_write(A_EN, 32'h01);
    bus_write(A_EDGE, 32'h00);
    check("idle_irq", {31'b0, irq}, 32'h0);
    src = 8'h01;
    tick(3);
    check("latency_e3_irq", {31'b0, irq}, 32'h0);
    tick(1);
    check("latency_e4_irq", {31'b0, irq}, 32'h1);
    bus_read(A_CLAIM, 32'd1, "claim_src0");
    tick(1);
    check("irq_after_claim", {31'b0, irq}, 32'h0);
    bus_write(A_CLAIM, 32'd1);
    check("irq_at_complete", {31'b0, irq}, 32'h0);
    tick(1);
    check("irq_after_complete", {31'b0, irq}, 32'h1);
    src = '0;
    tick(4);
    bus_write(A_EN, 32'h00);

    // priority
    bus_write(A_EN, 32'h24);
    src = 8'h24;
    tick(5);
    check("prio_irq", {31'b0, irq}, 32'h1);
    bus_read(A_PEND, 32'h24, "prio_pending");
    bus_read(A_CLAIM, 32'd3, "prio_claim1");
    bus_read(A_CLAIM, 32'd6, "prio_claim2");
    bus_read(A_CLAIM, 32'd0, "prio_claim3");
    check("prio_irq_low", {31'b0, irq}, 32'h0);
    bus_read(A_EN, 32'h24, "enable_readback");
    src = '0;
    tick(4);
    bus_write(A_CLAIM, 32'd3);
    bus_write(A_CLAIM, 32'd6);
    bus_write(A_EN, 32'h00);

    // edge mode and write-1-to-clear
    bus_write(A_EDGE, 32'h02);
    bus_write(A_EN, 32'h02);
    bus_read(A_EDGE, 32'h02, "edge_readback");
    src = 8'h02;
    tick(3);
    src = '0;
    tick(3);
    check("edge_irq", {31'b0, irq}, 32'h1);
    bus_read(A_PEND, 32'h02, "edge_pending");
    bus_read(A_CLAIM, 32'd2, "edge_claim");
    bus_read(A_PEND, 32'h00, "edge_pending_cleared");
    bus_write(A_CLAIM, 32'd2);
    src = 8'h02;
    tick(3);
    src = '0;
    tick(3);
    check("edge2_irq", {31'b0, irq}, 32'h1);
    bus_write(A_PEND, 32'h02);
    bus_read(A_PEND, 32'h00, "w1c_pending");
    check("w1c_irq", {31'b0, irq}, 32'h0);

    // set beats clear: W1C lands on the edge where sync2 rises
    src = 8'h02;
    tick(2);
    bus_write(A_PEND, 32'h02);
    bus_read(A_PEND, 32'h02, "set_beats_clear");
    src = '0;
    tick(3);
    bus_write(A_PEND, 32'h02);
    bus_write(A_EDGE, 32'h00);
    bus_write(A_EN, 32'h00);

    // simultaneous claim/complete and invalid completes
    bus_write(A_EN, 32'h89);
    src = 8'h01;
    tick(5);
    bus_read(A_CLAIM, 32'd1, "sc_claim_src0");
    src = 8'h89;
    tick(4);
    claim_and_complete(32'd1, 32'd4, "sc_claim_with_complete");
    bus_read(A_CLAIM, 32'd1, "sc_src0_released");
    bus_read(A_CLAIM, 32'd8, "sc_claim_src7");
    bus_read(A_CLAIM, 32'd0, "sc_all_in_service");
    bus_write(A_CLAIM, 32'd0);
    bus_write(A_CLAIM, 32'd9);
    bus_read(A_CLAIM, 32'd0, "invalid_complete");
    check("invalid_complete_irq", {31'b0, irq}, 32'h0);
    bus_write(A_CLAIM, 32'd4);
    bus_read(A_CLAIM, 32'd4, "valid_complete_src3");

    // asynchronous reset between edges
    bus_write(A_CLAIM, 32'd1);
    bus_read(A_EN, 32'h89, "pre_reset_enable");
    #5;
    check("pre_reset_rdata", rdata, 32'h89);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_reset_rdata", rdata, 32'h0);
    check("async_reset_irq", {31'b0, irq}, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);
    bus_read(A_EN, 32'h00, "post_reset_enable");
    bus_read(A_CLAIM, 32'd0, "post_reset_claim");
    tick(2);
    check("post_reset_irq", {31'b0, irq}, 32'h0);

    tick(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
